// File: rtl/aes_sbox_seq.sv
// Time-multiplexed AES SubBytes/InvSubBytes engine: LANES byte S-boxes sweep the
// 128-bit state in 16/LANES beats behind valid/ready handshakes.

module aes_sbox_lut (
  input  logic [7:0] byte_in,
  input  logic       dec,
  output logic [7:0] byte_out
);

  localparam logic [0:255][7:0] FWD = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  // The inverse table is derived from the forward one so the two can never disagree.
  function automatic logic [0:255][7:0] invert_table(input logic [0:255][7:0] t);
    logic [0:255][7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      r[t[i]] = 8'(i);
    end
    return r;
  endfunction

  localparam logic [0:255][7:0] INV = invert_table(FWD);

  assign byte_out = dec ? INV[byte_in] : FWD[byte_in];

endmodule

module aes_sbox (
  input  logic [7:0] U,
  input  logic       dec,
  output logic [7:0] S
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // a^254 by square-and-multiply; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  logic [7:0] inv_in;
  logic [7:0] inv_out;

  assign inv_in  = dec ? inv_affine(U) : U;
  assign inv_out = gf_inv(inv_in);
  assign S       = dec ? inv_out : affine(inv_out);

endmodule

module aes_sbox_seq #(
  parameter int LANES   = 4,
  parameter int SBOX_GF = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("aes_sbox_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [BW-1:0]    beat;
  logic             mode;
  logic [15:0][7:0] work;
  logic [15:0][7:0] work_next;
  logic             accept;
  logic             last_beat;
  logic [3:0]       lane_idx [LANES];
  logic [7:0]       lane_in  [LANES];
  logic [7:0]       lane_out [LANES];

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat == BW'(N - 1));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_idx[g] = 4'(int'(beat) * LANES + g);
    assign lane_in[g]  = work[lane_idx[g]];
    if (SBOX_GF == 0) begin : g_lut
      aes_sbox_lut u_sbox (
        .byte_in  (lane_in[g]),
        .dec      (mode),
        .byte_out (lane_out[g])
      );
    end else begin : g_gf
      aes_sbox u_sbox (
        .U   (lane_in[g]),
        .dec (mode),
        .S   (lane_out[g])
      );
    end
  end

  always_comb begin
    work_next = work;
    for (int l = 0; l < LANES; l++) begin
      work_next[lane_idx[l]] = lane_out[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_beat) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (accept) begin
          state_next = RUN;
        end else if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The final beat's substituted bytes go straight into out_data, saving a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      mode     <= 1'b0;
      beat     <= '0;
      out_data <= '0;
    end else if (accept) begin
      work <= in_data;
      mode <= in_dec;
      beat <= '0;
    end else if (state == RUN) begin
      work <= work_next;
      beat <= last_beat ? '0 : beat + BW'(1);
      if (last_beat) out_data <= work_next;
    end
  end

endmodule
